t5_ibus: RTL and testbench

T5_IBUS -- requirements
Module: t5_ibus

---
 rtl/t5_pkg.sv | 14 +
 rtl/t5_ibus.sv | 157 +++++++++++++++
 tb/tb_t5_ibus.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/t5_pkg.sv
// Shared definitions for the t5 instruction-fetch bus block: FSM states and
// the instruction word substituted on a failed fetch.
package t5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // RISC-V canonical NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/t5_ibus.sv
// Instruction-fetch bus bridge with a single-entry last-fetch buffer.
// Optional bus timeout compiled in with `define T5_IBUS_TIMEOUT_EN.
module t5_ibus
  import t5_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TOUT = 255
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            ireq,
  input  logic [XLEN-3:0] iadr,
  input  logic            iflush,
  output logic            iack,
  output logic [XLEN-1:0] idat,
  output logic            ifault,
  output logic            wb_stb,
  output logic [XLEN-3:0] wb_adr,
  input  logic            wb_ack,
  input  logic            wb_err,
  input  logic [XLEN-1:0] wb_dat
);

  state_t          state;
  state_t          state_nx;

  logic [XLEN-3:0] buf_adr;
  logic [XLEN-1:0] buf_dat;
  logic            buf_vld;
  logic            flush_pend;

  logic            hit;
  logic            take_hit;
  logic            start_miss;
  logic            ack_end;
  logic            fault_end;
  logic            tout_hit;

`ifdef T5_IBUS_TIMEOUT_EN
  localparam int TW = $clog2(TOUT + 1);

  logic [TW-1:0] tcnt;

  // counts cycles spent in BUSY; cleared everywhere else
  always_ff @(posedge sclk) begin
    if (srst || state != ST_BUSY) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tout_hit = (state == ST_BUSY) && (tcnt == TW'(TOUT - 1));
`else
  assign tout_hit = 1'b0;
`endif

  // a flush in the request cycle must never be served from the old buffer
  assign hit = buf_vld && !iflush && (buf_adr == iadr);

  always_ff @(posedge sclk) begin
    if (srst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    take_hit   = 1'b0;
    start_miss = 1'b0;
    ack_end    = 1'b0;
    fault_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ireq) begin
          if (hit) begin
            take_hit = 1'b1;
            state_nx = ST_DONE;
          end else begin
            start_miss = 1'b1;
            state_nx   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // error beats ack; a real ack beats a same-cycle timeout
        if (wb_err || (!wb_ack && tout_hit)) begin
          fault_end = 1'b1;
          state_nx  = ST_DONE;
        end else if (wb_ack) begin
          ack_end  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign iack = (state == ST_DONE);

  always_ff @(posedge sclk) begin
    if (srst) begin
      wb_stb     <= 1'b0;
      wb_adr     <= '0;
      idat       <= '0;
      ifault     <= 1'b0;
      buf_vld    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (start_miss) begin
        wb_stb <= 1'b1;
        wb_adr <= iadr;
      end else if (ack_end || fault_end) begin
        wb_stb <= 1'b0;
      end

      if (take_hit) begin
        idat   <= buf_dat;
        ifault <= 1'b0;
      end else if (ack_end) begin
        idat   <= wb_dat;
        ifault <= 1'b0;
      end else if (fault_end) begin
        idat   <= XLEN'(NOP_INSN);
        ifault <= 1'b1;
      end

      // a flush seen at any point during the bus cycle poisons its result
      if (state == ST_BUSY) begin
        flush_pend <= flush_pend | iflush;
      end else begin
        flush_pend <= 1'b0;
      end

      if (iflush) begin
        buf_vld <= 1'b0;
      end else if (ack_end && !flush_pend) begin
        buf_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (ack_end) begin
      buf_adr <= wb_adr;
      buf_dat <= wb_dat;
    end
  end

endmodule

// File: tb/tb_t5_ibus.sv
// Scoreboard bench for t5_ibus; define T5_IBUS_TIMEOUT_EN to add the
// bus-timeout scenario (DUT built with TOUT=4).
module tb_t5_ibus;
  import t5_pkg::*;

  localparam int XLEN = 32;
  localparam int TOUT = 4;

  logic            sclk;
  logic            srst;
  logic            ireq;
  logic [XLEN-3:0] iadr;
  logic            iflush;
  logic            iack;
  logic [XLEN-1:0] idat;
  logic            ifault;
  logic            wb_stb;
  logic [XLEN-3:0] wb_adr;
  logic            wb_ack;
  logic            wb_err;
  logic [XLEN-1:0] wb_dat;

  int n_chk  = 0;
  int n_fail = 0;

  logic [XLEN:0] sb[$];
  logic          iack_q = 1'b0;

  t5_ibus #(.XLEN(XLEN), .TOUT(TOUT)) dut (
    .sclk  (sclk),
    .srst  (srst),
    .ireq  (ireq),
    .iadr  (iadr),
    .iflush(iflush),
    .iack  (iack),
    .idat  (idat),
    .ifault(ifault),
    .wb_stb(wb_stb),
    .wb_adr(wb_adr),
    .wb_ack(wb_ack),
    .wb_err(wb_err),
    .wb_dat(wb_dat)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // response monitor: every iack consumes one scoreboard entry
  always @(negedge sclk) begin
    logic [XLEN:0] e;
    if (iack) begin
      if (sb.size() == 0) begin
        chk("spurious_iack", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("idat", 64'(idat), 64'(e[XLEN-1:0]));
        chk("ifault", 64'(ifault), 64'(e[XLEN]));
      end
      if (iack_q) chk("iack_twice", 1, 0);
    end
    iack_q = iack;
  end

  // One fetch. hit: expect served from buffer. dly: cycles after wb_stb seen
  // before the bus answers. err: bus error (ack driven high too).
  // fl: iflush with the request. bfl: iflush pulse during BUSY. drop: ireq
  // released once the bus cycle has started.
  task automatic fetch(input logic [XLEN-3:0] a, input bit hit, input int dly,
                       input logic [XLEN-1:0] d, input bit err, input bit fl,
                       input bit bfl, input bit drop);
    logic [XLEN:0] e;
    @(negedge sclk);
    ireq   = 1'b1;
    iadr   = a;
    iflush = fl;
    if (hit || !err) e = {1'b0, d};
    else             e = {1'b1, NOP_INSN};
    sb.push_back(e);
    @(negedge sclk);
    iflush = 1'b0;
    if (hit) begin
      chk("hit_iack", 64'(iack), 1);
      chk("hit_nostb", 64'(wb_stb), 0);
    end else begin
      chk("miss_stb", 64'(wb_stb), 1);
      chk("miss_adr", 64'(wb_adr), 64'(a));
      if (drop) ireq = 1'b0;
      for (int i = 0; i < dly; i++) begin
        if (bfl && i == 0) iflush = 1'b1;
        @(negedge sclk);
        iflush = 1'b0;
        chk("stb_hold", 64'(wb_stb), 1);
        chk("adr_hold", 64'(wb_adr), 64'(a));
        chk("no_early_iack", 64'(iack), 0);
      end
      wb_ack = 1'b1;
      wb_err = err;
      wb_dat = d;
      @(negedge sclk);
      wb_ack = 1'b0;
      wb_err = 1'b0;
      wb_dat = $urandom;
      chk("miss_iack", 64'(iack), 1);
      chk("stb_clr", 64'(wb_stb), 0);
    end
    ireq = 1'b0;
    @(negedge sclk);
    chk("iack_single", 64'(iack), 0);
  endtask

  initial begin
    srst   = 1'b1;
    ireq   = 1'b0;
    iadr   = '0;
    iflush = 1'b0;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_dat = '0;
    repeat (3) @(negedge sclk);
    chk("rst_iack", 64'(iack), 0);
    chk("rst_stb", 64'(wb_stb), 0);
    chk("rst_adr", 64'(wb_adr), 0);
    chk("rst_idat", 64'(idat), 0);
    chk("rst_ifault", 64'(ifault), 0);
    srst = 1'b0;

    // miss then hit on the same word
    fetch(30'h100, 0, 3, 32'hDEAD_BEEF, 0, 0, 0, 0);
    fetch(30'h100, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    repeat (3) @(negedge sclk);
    chk("idat_hold", 64'(idat), 64'h0000_0000_DEAD_BEEF);
    // flush with request forces the bus read
    fetch(30'h100, 0, 1, 32'h1234_5678, 0, 1, 0, 0);
    fetch(30'h100, 1, 0, 32'h1234_5678, 0, 0, 0, 0);
    // error with simultaneous ack, then same word misses
    fetch(30'h200, 0, 0, 32'hAAAA_5555, 1, 0, 0, 0);
    chk("fault_hold", 64'(ifault), 1);
    fetch(30'h200, 0, 2, 32'hCAFE_F00D, 0, 0, 0, 0);
    fetch(30'h200, 1, 0, 32'hCAFE_F00D, 0, 0, 0, 0);
    // flush during BUSY: result delivered but not buffered
    fetch(30'h300, 0, 2, 32'h0BAD_C0DE, 0, 0, 1, 0);
    fetch(30'h300, 0, 1, 32'h7777_0001, 0, 0, 0, 0);
    // request dropped mid-transaction still completes
    fetch(30'h3FF, 0, 2, 32'h5A5A_A5A5, 0, 0, 0, 1);
    fetch(30'h3FF, 1, 0, 32'h5A5A_A5A5, 0, 0, 0, 0);

    // reset two cycles after wb_stb, then a late ack
    @(negedge sclk);
    ireq = 1'b1;
    iadr = 30'h400;
    @(negedge sclk);
    chk("rb_stb", 64'(wb_stb), 1);
    repeat (2) @(negedge sclk);
    srst = 1'b1;
    ireq = 1'b0;
    @(negedge sclk);
    srst   = 1'b0;
    wb_ack = 1'b1;
    wb_dat = 32'h1111_2222;
    chk("rb_stb_clr", 64'(wb_stb), 0);
    chk("rb_adr_clr", 64'(wb_adr), 0);
    chk("rb_idat_clr", 64'(idat), 0);
    chk("rb_no_iack", 64'(iack), 0);
    @(negedge sclk);
    wb_ack = 1'b0;
    chk("rb_late_ack", 64'(iack), 0);
    chk("rb_late_stb", 64'(wb_stb), 0);
    @(negedge sclk);
    chk("rb_late_ack2", 64'(iack), 0);
    // buffer was invalidated: previously buffered word must miss
    fetch(30'h3FF, 0, 1, 32'h9999_8888, 0, 0, 0, 0);

`ifdef T5_IBUS_TIMEOUT_EN
    @(negedge sclk);
    ireq = 1'b1;
    iadr = 30'h500;
    sb.push_back({1'b1, NOP_INSN});
    for (int i = 0; i < TOUT; i++) begin
      @(negedge sclk);
      chk("to_stb", 64'(wb_stb), 1);
      chk("to_no_iack", 64'(iack), 0);
    end
    @(negedge sclk);
    chk("to_stb_fall", 64'(wb_stb), 0);
    chk("to_iack", 64'(iack), 1);
    ireq = 1'b0;
    @(negedge sclk);
    chk("to_iack_single", 64'(iack), 0);
`endif

    repeat (3) @(negedge sclk);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
